// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register-read stage with a busy scoreboard and a one-entry ID/EX register.
// Optional OF_STALL_CNT_EN adds a saturating 16-bit count of hazard-stalled decode cycles (stall_cnt).
module operand_fetch_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [ADDR_W-1:0] in_src1,
  input  logic [ADDR_W-1:0] in_src2,
  input  logic              in_use1,
  input  logic              in_use2,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic              in_wen,
  input  logic [DATA_W-1:0] in_imm,
  output logic [ADDR_W-1:0] rf_src1,
  output logic [ADDR_W-1:0] rf_src2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_dst,
  output logic              out_wen
`ifdef OF_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busyNext;
  logic clr1, clr2, clrDst;
  logic hazard;
  logic fire;
  assign rf_src1 = in_src1;
  assign rf_src2 = in_src2;
  assign clr1 = wb_valid && (wb_reg == in_src1);
  assign clr2 = wb_valid && (wb_reg == in_src2);
  assign clrDst = wb_valid && (wb_reg == in_dst);
  assign hazard = (in_use1 && busy[in_src1] && !clr1) ||
                  (in_use2 && busy[in_src2] && !clr2) ||
                  (in_wen && busy[in_dst] && !clrDst);
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign fire = in_valid && in_ready;
  // Scoreboard next state: writeback clears, issue sets (set wins), flush wipes everything
  always_comb begin
    busyNext = busy;
    if (wb_valid) busyNext[wb_reg] = 1'b0;
    if (fire && in_wen) busyNext[in_dst] = 1'b1;
    if (flush) busyNext = '0;
  end
  // Scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else busy <= busyNext;
  end
  // ID/EX valid: load on fire, drain when consumed, drop on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_valid <= 1'b0;
    else if (flush) out_valid <= 1'b0;
    else if (fire) out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end
  // ID/EX payload: only written on fire so it holds steady under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_opcode <= '0;
      out_op1 <= '0;
      out_op2 <= '0;
      out_imm <= '0;
      out_dst <= '0;
      out_wen <= 1'b0;
    end else if (fire) begin
      out_opcode <= in_opcode;
      out_op1 <= rf_data1;
      out_op2 <= rf_data2;
      out_imm <= in_imm;
      out_dst <= in_dst;
      out_wen <= in_wen;
    end
  end
`ifdef OF_STALL_CNT_EN
  // Count cycles where a presented instruction is held back by a hazard, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (in_valid && hazard && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed checks of issue, RAW/WAW stalls, backpressure, flush and async reset.
module tb_operand_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  logic inValid, inReady, inUse1, inUse2, inWen;
  logic [3:0] inOpcode;
  logic [3:0] inSrc1, inSrc2, inDst;
  logic [15:0] inImm;
  logic [3:0] rfSrc1, rfSrc2;
  logic [15:0] rfData1, rfData2;
  logic wbValid;
  logic [3:0] wbReg;
  logic [15:0] wbData;
  logic flush;
  logic outValid, outReady, outWen;
  logic [3:0] outOpcode, outDst;
  logic [15:0] outOp1, outOp2, outImm;
`ifdef OF_STALL_CNT_EN
  logic [15:0] stallCnt;
`endif
  logic [15:0] rf [16];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  assign rfData1 = (wbValid && wbReg == rfSrc1) ? wbData : rf[rfSrc1];
  assign rfData2 = (wbValid && wbReg == rfSrc2) ? wbData : rf[rfSrc2];
  operand_fetch_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in_opcode(inOpcode),
    .in_src1(inSrc1), .in_src2(inSrc2), .in_use1(inUse1), .in_use2(inUse2),
    .in_dst(inDst), .in_wen(inWen), .in_imm(inImm),
    .rf_src1(rfSrc1), .rf_src2(rfSrc2), .rf_data1(rfData1), .rf_data2(rfData2),
    .wb_valid(wbValid), .wb_reg(wbReg), .flush(flush),
    .out_valid(outValid), .out_ready(outReady), .out_opcode(outOpcode),
    .out_op1(outOp1), .out_op2(outOp2), .out_imm(outImm), .out_dst(outDst), .out_wen(outWen)
`ifdef OF_STALL_CNT_EN
    , .stall_cnt(stallCnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] op, input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                       input logic u2, input logic [3:0] d, input logic w, input logic [15:0] imm);
    inValid = 1'b1; inOpcode = op; inSrc1 = s1; inUse1 = u1; inSrc2 = s2; inUse2 = u2;
    inDst = d; inWen = w; inImm = imm;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'hA000 | 16'(i);
    rf[3] = 16'h1234;
    rf[5] = 16'h00FF;
    rst = 1'b0; flush = 1'b0; wbValid = 1'b0; wbReg = '0; wbData = '0; outReady = 1'b1;
    inValid = 1'b0; inOpcode = '0; inSrc1 = '0; inSrc2 = '0; inUse1 = 1'b0; inUse2 = 1'b0;
    inDst = '0; inWen = 1'b0; inImm = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset out_valid", 32'(outValid), 0);
    chk("reset out_op1", 32'(outOp1), 0);
    chk("reset out_opcode", 32'(outOpcode), 0);
    chk("reset in_ready", 32'(inReady), 1);
    rst = 1'b1;
    issue(4'h2, 4'd3, 1'b1, 4'd5, 1'b1, 4'd7, 1'b1, 16'h0042);
    #1;
    chk("basic in_ready", 32'(inReady), 1);
    chk("rf_src1 passthru", 32'(rfSrc1), 3);
    chk("rf_src2 passthru", 32'(rfSrc2), 5);
    tick();
    issue(4'h3, 4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 16'h0011);
    #1;
    chk("basic out_valid", 32'(outValid), 1);
    chk("basic out_op1", 32'(outOp1), 32'h1234);
    chk("basic out_op2", 32'(outOp2), 32'h00FF);
    chk("basic out_dst", 32'(outDst), 7);
    chk("basic out_opcode", 32'(outOpcode), 2);
    chk("basic out_imm", 32'(outImm), 32'h42);
    chk("basic out_wen", 32'(outWen), 1);
    chk("raw stall c0", 32'(inReady), 0);
    for (int k = 1; k <= 2; k++) begin
      tick();
      #1;
      chk("raw stall", 32'(inReady), 0);
      chk("raw drained out_valid", 32'(outValid), 0);
      chk("raw hold out_op1", 32'(outOp1), 32'h1234);
    end
    tick();
    wbValid = 1'b1; wbReg = 4'd7; wbData = 16'hBEEF;
    #1;
    chk("raw wb release", 32'(inReady), 1);
    tick();
    wbValid = 1'b0;
    rf[7] = 16'hBEEF;
    #1;
    chk("raw bypass out_op1", 32'(outOp1), 32'hBEEF);
    chk("raw out_opcode", 32'(outOpcode), 3);
    chk("raw out_dst", 32'(outDst), 8);
`ifdef OF_STALL_CNT_EN
    chk("stall_cnt raw", 32'(stallCnt), 3);
`endif
    issue(4'h4, 4'd7, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 16'h000C);
    #1;
    chk("busy7 cleared", 32'(inReady), 1);
    outReady = 1'b0;
    #1;
    chk("bp in_ready", 32'(inReady), 0);
    repeat (4) begin
      tick();
      #1;
      chk("bp in_ready", 32'(inReady), 0);
      chk("bp out_valid", 32'(outValid), 1);
      chk("bp out_opcode", 32'(outOpcode), 3);
      chk("bp out_op1", 32'(outOp1), 32'hBEEF);
      chk("bp out_op2", 32'(outOp2), 32'hA000);
    end
    outReady = 1'b1;
    #1;
    chk("bp release in_ready", 32'(inReady), 1);
    tick();
    #1;
    chk("bp new out_opcode", 32'(outOpcode), 4);
    chk("bp new out_op1", 32'(outOp1), 32'hBEEF);
    chk("bp new out_op2", 32'(outOp2), 32'h00FF);
    chk("bp new out_valid", 32'(outValid), 1);
    issue(4'h5, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 16'h0005);
    tick();
    issue(4'h6, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 16'h0006);
    tick();
    issue(4'h7, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0007);
    #1;
    chk("pre-flush out_opcode", 32'(outOpcode), 6);
    chk("pre-flush hazard", 32'(inReady), 0);
    flush = 1'b1;
    #1;
    chk("flush in_ready", 32'(inReady), 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush out_valid", 32'(outValid), 0);
    chk("flush busy9 cleared", 32'(inReady), 1);
    tick();
    #1;
    chk("post-flush out_valid", 32'(outValid), 1);
    chk("post-flush out_opcode", 32'(outOpcode), 7);
    chk("post-flush out_op1", 32'(outOp1), 32'hA009);
    issue(4'h8, 4'd2, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 16'h0008);
    #1;
    chk("flush busy2 cleared", 32'(inReady), 1);
    tick();
    issue(4'h9, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 16'h0099);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("waw stall", 32'(inReady), 0);
      tick();
    end
    wbValid = 1'b1; wbReg = 4'd4; wbData = 16'h4444;
    #1;
    chk("waw wb release", 32'(inReady), 1);
    tick();
    wbValid = 1'b0;
    rf[4] = 16'h4444;
`ifdef OF_STALL_CNT_EN
    chk("stall_cnt waw", 32'(stallCnt), 8);
`endif
    #1;
    chk("waw out_opcode", 32'(outOpcode), 9);
    chk("waw out_imm", 32'(outImm), 32'h99);
    issue(4'hA, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h000A);
    #1;
    chk("waw set wins busy4", 32'(inReady), 0);
    issue(4'hA, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 16'h00AA);
    #1;
    chk("pre-reset issue", 32'(inReady), 1);
    tick();
    inValid = 1'b0;
    #2;
    chk("pre-reset out_valid", 32'(outValid), 1);
    rst = 1'b0;
    #1;
    chk("async rst out_valid", 32'(outValid), 0);
    chk("async rst out_opcode", 32'(outOpcode), 0);
    chk("async rst out_imm", 32'(outImm), 0);
    chk("async rst out_dst", 32'(outDst), 0);
    chk("async rst out_wen", 32'(outWen), 0);
    rst = 1'b1;
    issue(4'hB, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h000B);
    #1;
    chk("rst busy7 cleared", 32'(inReady), 1);
    tick();
    inValid = 1'b0;
    #1;
    chk("post-rst out_valid", 32'(outValid), 1);
    chk("post-rst out_opcode", 32'(outOpcode), 32'hB);
    chk("post-rst out_op1", 32'(outOp1), 32'hBEEF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
